// File: rtl/fpga_mem_pkg.sv
// Definitions shared by the memory responder and the upstream controller:
// phase states, beat width and line geometry.
package fpga_mem_pkg;
  localparam int BEAT_W     = 32;
  localparam int LINE_BEATS = 8;
  localparam int BEAT_IDX_W = $clog2(LINE_BEATS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RDATA = 3'd4,
    HOLD  = 3'd5
  } mem_state_e;
endpackage

// File: rtl/fpga_mem_array.sv
// Single-port backing store: synchronous write, combinational read.
// Contents are deliberately not reset.
module fpga_mem_array
  import fpga_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BEAT_W-1:0] wdata,
  output logic [BEAT_W-1:0] rdata
);
  logic [BEAT_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

// File: rtl/fpga_mem_responder.sv
// Memory-side responder for the multiplexed address/data bus: one resp per
// address beat, per data beat and per write completion, with a holdoff after each.
module fpga_mem_responder
  import fpga_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RESP_LAT    = 1,
  parameter int HOLDOFF     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] address_data_bus_c_to_m,
  input  logic              address_on_c_to_m,
  input  logic              data_on_c_to_m,
  input  logic              read_en_c_to_m,
  input  logic              write_en_c_to_m,
  output logic [BEAT_W-1:0] address_data_bus_m_to_c,
  output logic              resp_m_to_c,
  output logic              proto_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  mem_state_e            state, after_hold, fire_next;
  logic [26:0]           line;
  logic                  is_wr;
  logic [BEAT_IDX_W-1:0] beat;
  logic                  busy;
  logic [1:0]            lat_cnt;
  logic [HW-1:0]         hold_cnt;
  logic                  violation, acc, fire, mem_we, last_beat;
  logic [AW-1:0]         word_addr;
  logic [BEAT_W-1:0]     mem_rdata;

  // Line-relative word index; the cast truncates to the store size (mod DEPTH_WORDS).
  assign word_addr = AW'({line, beat});
  assign last_beat = (beat == BEAT_IDX_W'(LINE_BEATS - 1));

  always_comb begin
    violation = (address_on_c_to_m & data_on_c_to_m) | (read_en_c_to_m & write_en_c_to_m);
    acc       = 1'b0;
    fire_next = IDLE;
    case (state)
      IDLE:  acc = address_on_c_to_m & (read_en_c_to_m ^ write_en_c_to_m) & ~violation;
      WDATA: acc = ~busy & data_on_c_to_m & write_en_c_to_m & ~violation;
      RDATA: acc = ~busy & data_on_c_to_m & read_en_c_to_m & ~violation;
      WRESP: acc = ~busy & ~violation;
      default: acc = 1'b0;
    endcase
    case (state)
      IDLE:    fire_next = write_en_c_to_m ? WDATA : RDATA;
      ADDR:    fire_next = is_wr ? WDATA : RDATA;
      WDATA:   fire_next = last_beat ? WRESP : WDATA;
      RDATA:   fire_next = last_beat ? IDLE : RDATA;
      default: fire_next = IDLE;
    endcase
    fire   = (acc && RESP_LAT == 1) || (busy && lat_cnt == 2'd1);
    mem_we = acc && (state == WDATA);
  end

  fpga_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_addr),
    .wdata (address_data_bus_c_to_m),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= IDLE;
      after_hold              <= IDLE;
      line                    <= '0;
      is_wr                   <= 1'b0;
      beat                    <= '0;
      busy                    <= 1'b0;
      lat_cnt                 <= '0;
      hold_cnt                <= '0;
      resp_m_to_c             <= 1'b0;
      address_data_bus_m_to_c <= '0;
      proto_err               <= 1'b0;
    end else begin
      resp_m_to_c             <= 1'b0;
      address_data_bus_m_to_c <= '0;
      if (state != HOLD && violation) proto_err <= 1'b1;

      if (acc) begin
        if (state == IDLE) begin
          line  <= address_data_bus_c_to_m[31:5];
          is_wr <= write_en_c_to_m;
          beat  <= '0;
          state <= ADDR;
        end
        busy    <= (RESP_LAT > 1);
        lat_cnt <= 2'(RESP_LAT - 1);
      end else if (busy && lat_cnt != 2'd1) begin
        lat_cnt <= lat_cnt - 2'd1;
      end

      // The resp edge also decides where the holdoff leads.
      if (fire) begin
        resp_m_to_c <= 1'b1;
        busy        <= 1'b0;
        if (state == RDATA) address_data_bus_m_to_c <= mem_rdata;
        if (state == WDATA || state == RDATA) beat <= beat + 1'b1;
        if (HOLDOFF == 0) begin
          state <= fire_next;
        end else begin
          state      <= HOLD;
          hold_cnt   <= HW'(HOLDOFF);
          after_hold <= fire_next;
        end
      end else if (state == HOLD) begin
        if (hold_cnt == '0) state <= after_hold;
        else                hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end
endmodule
